// File: rtl/ebike_stim_pkg.sv
// Shared types, widths and hall table for the eBike stimulus sequencer.
// Optional status outputs are enabled with EBIKE_STIM_STATUS_EN (see ebike_stim_seq).
package ebike_stim_pkg;

  localparam int unsigned STIM_CNT_W = 16;
  localparam int unsigned STIM_DUR_W = 24;
  localparam int unsigned HALL_LEN   = 6;

  typedef struct packed {
    logic [STIM_CNT_W-1:0] cad_half;
    logic [STIM_CNT_W-1:0] hall_step;
    logic [STIM_DUR_W-1:0] dur;
    logic                  rev;
    logic                  tggl;
  } stim_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stim_state_t;

  // Forward six-step order of {Grn,Ylw,Blu}; reverse walks it backwards.
  localparam logic [2:0] HALL_SEQ [HALL_LEN] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  function automatic logic [2:0] hallAdvance(input logic [2:0] pos, input logic rev);
    if (rev) return (pos == 3'd0) ? 3'd5 : pos - 3'd1;
    return (pos == 3'd5) ? 3'd0 : pos + 3'd1;
  endfunction

endpackage

// File: rtl/ebike_stim_fifo.sv
// Synchronous command FIFO; extra pointer bit separates full from empty.
// Full/empty flags are registered from the next-pointer values.
module ebike_stim_fifo
  import ebike_stim_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      RST_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  stim_cmd_t wrData,
  output stim_cmd_t rdData_c,
  output logic      notFull,
  output logic      empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  stim_cmd_t      mem [DEPTH];
  logic [AW:0]    wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic           doPush, doPop;

  assign doPush = push && notFull && !flush;
  assign doPop  = pop && !empty && !flush;

  always_comb begin
    wrPtrNext = wrPtr;
    rdPtrNext = rdPtr;
    if (flush) begin
      wrPtrNext = '0;
      rdPtrNext = '0;
    end else begin
      if (doPush) wrPtrNext = wrPtr + (AW+1)'(1);
      if (doPop)  rdPtrNext = rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      notFull <= 1'b1;
      empty   <= 1'b1;
    end else begin
      wrPtr   <= wrPtrNext;
      rdPtr   <= rdPtrNext;
      notFull <= !((wrPtrNext[AW] != rdPtrNext[AW]) &&
                   (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]));
      empty   <= (wrPtrNext == rdPtrNext);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
  end

  assign rdData_c = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/ebike_stim_seq.sv
// Segment-queue stimulus sequencer driving cadence, hall and tgglMd of the eBike DUT.
// Define EBIKE_STIM_STATUS_EN to add the seg_cnt and ovf_err status outputs.
module ebike_stim_seq
  import ebike_stim_pkg::*;
#(
  parameter int unsigned CNT_W     = STIM_CNT_W,
  parameter int unsigned DUR_W     = STIM_DUR_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PRESS_CYC = 1024
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic [CNT_W-1:0] cmd_cad_half,
  input  logic [CNT_W-1:0] cmd_hall_step,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             cmd_rev,
  input  logic             cmd_tggl,
  input  logic             abort,
  output logic             cadence,
  output logic             hallGrn,
  output logic             hallYlw,
  output logic             hallBlu,
  output logic             tgglMd,
  output logic             busy,
  output logic             seg_done
`ifdef EBIKE_STIM_STATUS_EN
  ,
  output logic [7:0]       seg_cnt,
  output logic             ovf_err
`endif
);

  localparam int unsigned PRESS_W = $clog2(PRESS_CYC + 1);

  stim_state_t        state, stateNext;
  stim_cmd_t          wrCmd, head;
  logic               push, pop, load, fifoNotFull, fifoEmpty;
  logic [DUR_W-1:0]   durCnt, durCntNext;
  logic [CNT_W-1:0]   cadHalf, cadHalfNext, cadCnt, cadCntNext;
  logic [CNT_W-1:0]   hallStep, hallStepNext, hallCnt, hallCntNext;
  logic               rev, revNext;
  logic [2:0]         hallPos, hallPosNext, hallNext;
  logic [PRESS_W-1:0] pressCnt, pressCntNext;
  logic               cadenceNext, tgglMdNext, busyNext, segDoneNext;

  assign wrCmd.cad_half  = STIM_CNT_W'(cmd_cad_half);
  assign wrCmd.hall_step = STIM_CNT_W'(cmd_hall_step);
  assign wrCmd.dur       = STIM_DUR_W'(cmd_dur);
  assign wrCmd.rev       = cmd_rev;
  assign wrCmd.tggl      = cmd_tggl;

  assign push    = cmd_vld && cmd_rdy && !abort;
  assign cmd_rdy = fifoNotFull;

  ebike_stim_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .RST_n    (RST_n),
    .push     (push),
    .pop      (pop),
    .flush    (abort),
    .wrData   (wrCmd),
    .rdData_c (head),
    .notFull  (fifoNotFull),
    .empty    (fifoEmpty)
  );

  // Sequencer: segment timing, cadence/hall generators and button press.
  always_comb begin
    stateNext    = state;
    pop          = 1'b0;
    load         = 1'b0;
    durCntNext   = durCnt;
    cadHalfNext  = cadHalf;
    cadCntNext   = cadCnt;
    hallStepNext = hallStep;
    hallCntNext  = hallCnt;
    revNext      = rev;
    hallPosNext  = hallPos;
    pressCntNext = pressCnt;
    cadenceNext  = cadence;
    tgglMdNext   = tgglMd;
    segDoneNext  = 1'b0;

    if (pressCnt != '0) begin
      pressCntNext = pressCnt - PRESS_W'(1);
      if (pressCnt == PRESS_W'(1)) tgglMdNext = 1'b1;
    end

    case (state)
      IDLE: begin
        cadenceNext = 1'b0;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          load      = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        durCntNext = durCnt - DUR_W'(1);
        if (cadHalf == '0) begin
          cadenceNext = 1'b0;
        end else if (cadCnt == CNT_W'(1)) begin
          cadenceNext = !cadence;
          cadCntNext  = cadHalf;
        end else begin
          cadCntNext = cadCnt - CNT_W'(1);
        end
        if (hallStep != '0) begin
          if (hallCnt == CNT_W'(1)) begin
            hallPosNext = hallAdvance(hallPos, rev);
            hallCntNext = hallStep;
          end else begin
            hallCntNext = hallCnt - CNT_W'(1);
          end
        end
        // Last cycle of the segment: chain straight into the next one if queued.
        if (durCnt == DUR_W'(1)) begin
          segDoneNext = 1'b1;
          if (!fifoEmpty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            stateNext   = IDLE;
            cadenceNext = 1'b0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (load) begin
      durCntNext   = (head.dur == '0) ? DUR_W'(1) : DUR_W'(head.dur);
      cadHalfNext  = CNT_W'(head.cad_half);
      cadCntNext   = CNT_W'(head.cad_half);
      hallStepNext = CNT_W'(head.hall_step);
      hallCntNext  = CNT_W'(head.hall_step);
      revNext      = head.rev;
      if (head.cad_half == '0) cadenceNext = 1'b0;
      if (head.tggl && (pressCnt == '0)) begin
        pressCntNext = PRESS_W'(PRESS_CYC);
        tgglMdNext   = 1'b0;
      end
    end

    if (abort) begin
      stateNext    = IDLE;
      pop          = 1'b0;
      hallPosNext  = hallPos;
      pressCntNext = '0;
      cadenceNext  = 1'b0;
      tgglMdNext   = 1'b1;
      segDoneNext  = 1'b0;
    end

    busyNext = (stateNext == RUN);
    hallNext = HALL_SEQ[hallPosNext];
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      durCnt   <= '0;
      cadHalf  <= '0;
      cadCnt   <= '0;
      hallStep <= '0;
      hallCnt  <= '0;
      rev      <= 1'b0;
      hallPos  <= '0;
      pressCnt <= '0;
      cadence  <= 1'b0;
      {hallGrn, hallYlw, hallBlu} <= HALL_SEQ[0];
      tgglMd   <= 1'b1;
      busy     <= 1'b0;
      seg_done <= 1'b0;
    end else begin
      state    <= stateNext;
      durCnt   <= durCntNext;
      cadHalf  <= cadHalfNext;
      cadCnt   <= cadCntNext;
      hallStep <= hallStepNext;
      hallCnt  <= hallCntNext;
      rev      <= revNext;
      hallPos  <= hallPosNext;
      pressCnt <= pressCntNext;
      cadence  <= cadenceNext;
      {hallGrn, hallYlw, hallBlu} <= hallNext;
      tgglMd   <= tgglMdNext;
      busy     <= busyNext;
      seg_done <= segDoneNext;
    end
  end

`ifdef EBIKE_STIM_STATUS_EN
  // Segment counter follows seg_done; overflow flag is sticky until reset.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      seg_cnt <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (abort) seg_cnt <= '0;
      else if (segDoneNext) seg_cnt <= seg_cnt + 8'd1;
      if (cmd_vld && !fifoNotFull) ovf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ebike_stim_seq.sv
// Scoreboard bench for ebike_stim_seq: directed segments with hand-computed output change times.
module tb_ebike_stim_seq;

  localparam int NSIG = 6;
  localparam int S_BUSY = 0, S_DONE = 1, S_CAD = 2, S_HALL = 3, S_TGGL = 4, S_RDY = 5;

  logic        clk = 1'b0;
  logic        RST_n;
  logic        cmd_vld, cmd_rdy, cmd_rev, cmd_tggl, abort;
  logic [15:0] cmd_cad_half, cmd_hall_step;
  logic [23:0] cmd_dur;
  logic        cadence, hallGrn, hallYlw, hallBlu, tgglMd, busy, seg_done;
`ifdef EBIKE_STIM_STATUS_EN
  logic [7:0]  seg_cnt;
  logic        ovf_err;
`endif

  ebike_stim_seq dut (
    .clk(clk), .RST_n(RST_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .cmd_cad_half(cmd_cad_half), .cmd_hall_step(cmd_hall_step), .cmd_dur(cmd_dur),
    .cmd_rev(cmd_rev), .cmd_tggl(cmd_tggl), .abort(abort), .cadence(cadence),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu), .tgglMd(tgglMd),
    .busy(busy), .seg_done(seg_done)
`ifdef EBIKE_STIM_STATUS_EN
    , .seg_cnt(seg_cnt), .ovf_err(ovf_err)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int sig; int cyc; int val; } ev_t;
  ev_t expq[$];
  int  nChecks = 0, nPass = 0, schedErr = 0;
  bit  monOn = 0, finalReq = 0, finalDone = 0;

  function automatic int hallCode(input int p);
    case (p)
      0: return 5; 1: return 4; 2: return 6; 3: return 2; 4: return 3; default: return 1;
    endcase
  endfunction

  function automatic string sigName(input int s);
    case (s)
      S_BUSY: return "busy"; S_DONE: return "seg_done"; S_CAD: return "cadence";
      S_HALL: return "hall"; S_TGGL: return "tgglMd"; default: return "cmd_rdy";
    endcase
  endfunction

  task automatic ev(input int s, input int c, input int v);
    ev_t e;
    e.sig = s; e.cyc = c; e.val = v;
    expq.push_back(e);
  endtask

  // Monitor side: match each observed output change against the oldest expectation.
  task automatic monCheck(input int s, input int v, input bit timed);
    int idx = -1;
    for (int i = 0; i < expq.size(); i++)
      if (expq[i].sig == s) begin idx = i; break; end
    nChecks++;
    if (idx < 0) begin
      $display("FAIL %s unexpected change to %0d at cycle %0d, required no change", sigName(s), v, cyc);
    end else begin
      if (expq[idx].val == v && (!timed || expq[idx].cyc == cyc)) nPass++;
      else $display("FAIL %s got %0d at cycle %0d, required %0d at cycle %0d",
                    sigName(s), v, cyc, expq[idx].val, expq[idx].cyc);
      expq.delete(idx);
    end
  endtask

  initial begin
    int  cur[NSIG];
    int  prev[NSIG];
    bit  started = 0;
    forever begin
      @(negedge clk);
      if (monOn) begin
        cur[S_BUSY] = int'(busy);
        cur[S_DONE] = int'(seg_done);
        cur[S_CAD]  = int'(cadence);
        cur[S_HALL] = int'({hallGrn, hallYlw, hallBlu});
        cur[S_TGGL] = int'(tgglMd);
        cur[S_RDY]  = int'(cmd_rdy);
        for (int s = 0; s < NSIG; s++)
          if (!started || cur[s] != prev[s]) monCheck(s, cur[s], started);
        prev = cur;
        started = 1;
`ifdef EBIKE_STIM_STATUS_EN
        if (cyc == 2575) begin
          nChecks++;
          if (ovf_err === 1'b1) nPass++;
          else $display("FAIL ovf_err got %0b, required 1", ovf_err);
        end
`endif
        if (finalReq && !finalDone) begin
          nChecks++;
          if (expq.size() == 0 && schedErr == 0) nPass++;
          else $display("FAIL end_of_run %0d expected changes never seen, %0d schedule slips, required 0/0",
                        expq.size(), schedErr);
          foreach (expq[i])
            $display("FAIL missing %s -> %0d at cycle %0d", sigName(expq[i].sig), expq[i].val, expq[i].cyc);
          finalDone = 1;
        end
      end
    end
  end

  // Stimulus side: drive at the negedge just before posedge number n.
  task automatic waitBefore(input int n);
    @(negedge clk);
    while (cyc < n - 1) @(negedge clk);
    if (cyc != n - 1) schedErr++;
  endtask

  task automatic pushCmd(input int n, input int cad, input int hs, input int dur,
                         input bit rv, input bit tg);
    waitBefore(n);
    cmd_vld       = 1'b1;
    cmd_cad_half  = 16'(cad);
    cmd_hall_step = 16'(hs);
    cmd_dur       = 24'(dur);
    cmd_rev       = rv;
    cmd_tggl      = tg;
  endtask

  task automatic quiet(input int n);
    waitBefore(n);
    cmd_vld = 1'b0;
    abort   = 1'b0;
  endtask

  initial begin
    // Reset values.
    ev(S_BUSY, -1, 0); ev(S_DONE, -1, 0); ev(S_CAD, -1, 0);
    ev(S_HALL, -1, 5); ev(S_TGGL, -1, 1); ev(S_RDY, -1, 1);
    // Single forward segment, loaded at edge 6: C=100, H=50, D=1000.
    ev(S_BUSY, 6, 1); ev(S_BUSY, 1006, 0);
    ev(S_DONE, 1006, 1); ev(S_DONE, 1007, 0);
    for (int k = 1; k <= 9; k++) ev(S_CAD, 6 + 100 * k, k % 2);
    ev(S_CAD, 1006, 0);
    for (int k = 1; k <= 20; k++) ev(S_HALL, 6 + 50 * k, hallCode(k % 6));
    // Back-to-back: A(C=60,H=30,D=200) at 1021, B(C=50,H=20,D=100,rev) at 1221.
    ev(S_BUSY, 1021, 1); ev(S_BUSY, 1321, 0);
    ev(S_DONE, 1221, 1); ev(S_DONE, 1222, 0); ev(S_DONE, 1321, 1); ev(S_DONE, 1322, 0);
    ev(S_CAD, 1081, 1); ev(S_CAD, 1141, 0); ev(S_CAD, 1201, 1); ev(S_CAD, 1271, 0);
    for (int k = 1; k <= 6; k++) ev(S_HALL, 1021 + 30 * k, hallCode((2 + k) % 6));
    for (int k = 1; k <= 5; k++) ev(S_HALL, 1221 + 20 * k, hallCode((2 - k + 6) % 6));
    // Press of 1024 cycles spanning two segments (D=300 then D=900, both tggl).
    ev(S_BUSY, 1341, 1); ev(S_BUSY, 2541, 0);
    ev(S_DONE, 1641, 1); ev(S_DONE, 1642, 0); ev(S_DONE, 2541, 1); ev(S_DONE, 2542, 0);
    ev(S_TGGL, 1341, 0); ev(S_TGGL, 2365, 1);
    // Long segment (C=40,H=25) from 2561, FIFO filled, abort at edge 2610.
    ev(S_BUSY, 2561, 1); ev(S_RDY, 2568, 0);
    ev(S_CAD, 2601, 1); ev(S_HALL, 2586, hallCode(4));
    ev(S_BUSY, 2610, 0); ev(S_RDY, 2610, 1); ev(S_CAD, 2610, 0);
    // dur=0 runs for one cycle.
    ev(S_BUSY, 2651, 1); ev(S_BUSY, 2652, 0); ev(S_DONE, 2652, 1); ev(S_DONE, 2653, 0);

    RST_n = 1'b0; cmd_vld = 1'b0; abort = 1'b0; cmd_rev = 1'b0; cmd_tggl = 1'b0;
    cmd_cad_half = '0; cmd_hall_step = '0; cmd_dur = '0;
    waitBefore(3);
    RST_n = 1'b1;
    monOn = 1;

    pushCmd(5, 100, 50, 1000, 0, 0);
    quiet(6);
    pushCmd(1020, 60, 30, 200, 0, 0);
    pushCmd(1021, 50, 20, 100, 1, 0);
    quiet(1022);
    pushCmd(1340, 0, 0, 300, 0, 1);
    pushCmd(1341, 0, 0, 900, 0, 1);
    quiet(1342);
    pushCmd(2560, 40, 25, 5000, 0, 0);
    for (int i = 1; i <= 9; i++) pushCmd(2560 + i, 3, 2, 10 + i, 0, 0);
    quiet(2573);
    waitBefore(2610);
    abort = 1'b1;
    quiet(2611);
    pushCmd(2620, 5, 5, 50, 0, 1);
    abort = 1'b1;
    quiet(2621);
    pushCmd(2650, 0, 0, 0, 0, 0);
    quiet(2651);

    waitBefore(2700);
    finalReq = 1;
    for (int i = 0; i < 100 && !finalDone; i++) @(posedge clk);
    if (!finalDone) begin
      $display("FAIL monitor never completed the end-of-run check");
      $fatal(1);
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
